mem_access_stage: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline register bundle.
- Performs data-memory reads and writes over a req/ack handshake with variable latency, and stalls upstream while an access is outstanding.
- Drives the output port and loads the MEM/WB pipeline register (write-back data, destination, return-PC).
- Sits between EX_MEM_Reg and the write-back stage in the 8-bit pipelined processor.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/dmem_handshake.sv | 83 ++++++++
 rtl/mem_access_stage.sv | 111 +++++++++++
 tb/tb_mem_access_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: handshake FSM states
// and the write-back source select codes.
package mem_stage_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_IN  = 2'b10;
  localparam logic [1:0] WB_SEL_WD  = 2'b11;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack handshake: issues one access per memory instruction,
// waits a bounded number of cycles for the ack, and keeps the returned data
// for the write-back stage. A missing ack sets a sticky error flag.
module dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wd,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          dmem_err,
  output logic [DW-1:0] rdata_q,
  output state_t        state
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          access;

  assign access = rd_en | wr_en;

  // IDLE launches the request, BUSY waits for ack or timeout, DONE lets the
  // stalled instruction retire once without re-issuing its access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_err   <= 1'b0;
      rdata_q    <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= wr_en;
            dmem_addr  <= mem_addr;
            dmem_wdata <= mem_wd;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            rdata_q  <= '0;
            dmem_req <= 1'b0;
            dmem_err <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the 8-bit pipeline: runs data-memory accesses through the
// handshake block, stalls upstream while one is outstanding, drives the
// output port and loads the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_regf_M,
  input  logic          wr_en_dmem_M,
  input  logic          rd_en_M,
  input  logic          out_port_sel_M,
  input  logic          is_ret_M,
  input  logic [1:0]    mux_rdata_sel_M,
  input  logic [DW-1:0] alu_out_M,
  input  logic [1:0]    rd_M,
  input  logic [DW-1:0] IN_PORT_M,
  input  logic [AW-1:0] mem_addr_M,
  input  logic [DW-1:0] mem_wd_M,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          stall_M,
  output logic          dmem_err,
  output logic [DW-1:0] OUT_PORT,
  output logic          wr_en_regf_W,
  output logic [1:0]    rd_W,
  output logic [DW-1:0] wb_data_W,
  output logic [DW-1:0] ret_pc_W,
  output logic          ret_valid_W
);

  state_t        state;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] wb_next;
  logic          access_M;
  logic          load_wb;
  logic          ret_done;

  dmem_handshake #(
    .DW       (DW),
    .AW       (AW),
    .MAX_WAIT (MAX_WAIT)
  ) u_handshake (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en_M),
    .wr_en      (wr_en_dmem_M),
    .mem_addr   (mem_addr_M),
    .mem_wd     (mem_wd_M),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .dmem_err   (dmem_err),
    .rdata_q    (rdata_q),
    .state      (state)
  );

  assign access_M = rd_en_M | wr_en_dmem_M;
  assign stall_M  = ((state == IDLE) && access_M) || (state == BUSY);
  assign load_wb  = ((state == IDLE) && !access_M) || (state == DONE);
  assign ret_done = (state == DONE) && is_ret_M && rd_en_M;

  // Select the write-back value; memory data is only meaningful in DONE.
  always_comb begin
    wb_next = alu_out_M;
    case (mux_rdata_sel_M)
      WB_SEL_ALU: wb_next = alu_out_M;
      WB_SEL_MEM: wb_next = (state == DONE) ? rdata_q : '0;
      WB_SEL_IN:  wb_next = IN_PORT_M;
      WB_SEL_WD:  wb_next = mem_wd_M;
      default:    wb_next = alu_out_M;
    endcase
  end

  // MEM/WB register and output port: load on non-stalled cycles, bubble otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_regf_W <= 1'b0;
      rd_W         <= '0;
      wb_data_W    <= '0;
      ret_pc_W     <= '0;
      ret_valid_W  <= 1'b0;
      OUT_PORT     <= '0;
    end else begin
      wr_en_regf_W <= load_wb ? wr_en_regf_M : 1'b0;
      ret_valid_W  <= ret_done;
      if (load_wb) begin
        rd_W      <= rd_M;
        wb_data_W <= wb_next;
      end
      if (ret_done) begin
        ret_pc_W <= rdata_q;
      end
      if (load_wb && out_port_sel_M) begin
        OUT_PORT <= alu_out_M;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage. The bench plays both the upstream
// pipeline (holding an instruction until stall_M drops) and the data memory
// (a 256-byte array answering after a chosen number of BUSY cycles).
module tb_mem_access_stage;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en_regf_M, wr_en_dmem_M, rd_en_M, out_port_sel_M, is_ret_M;
  logic [1:0] mux_rdata_sel_M, rd_M;
  logic [7:0] alu_out_M, IN_PORT_M, mem_addr_M, mem_wd_M;
  logic       dmem_req, dmem_we, dmem_ack, stall_M, dmem_err;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata, OUT_PORT;
  logic       wr_en_regf_W, ret_valid_W;
  logic [1:0] rd_W;
  logic [7:0] wb_data_W, ret_pc_W;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] out_m;
  logic [7:0] ret_pc_m;
  logic       err_m;

  mem_access_stage #(.DW(8), .AW(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_en_regf_M    (wr_en_regf_M),
    .wr_en_dmem_M    (wr_en_dmem_M),
    .rd_en_M         (rd_en_M),
    .out_port_sel_M  (out_port_sel_M),
    .is_ret_M        (is_ret_M),
    .mux_rdata_sel_M (mux_rdata_sel_M),
    .alu_out_M       (alu_out_M),
    .rd_M            (rd_M),
    .IN_PORT_M       (IN_PORT_M),
    .mem_addr_M      (mem_addr_M),
    .mem_wd_M        (mem_wd_M),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .stall_M         (stall_M),
    .dmem_err        (dmem_err),
    .OUT_PORT        (OUT_PORT),
    .wr_en_regf_W    (wr_en_regf_W),
    .rd_W            (rd_W),
    .wb_data_W       (wb_data_W),
    .ret_pc_W        (ret_pc_W),
    .ret_valid_W     (ret_valid_W)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic setInputs(input logic wr_rf, input logic wr_mem, input logic rd_mem,
                           input logic out_sel, input logic is_ret, input logic [1:0] sel,
                           input logic [7:0] alu, input logic [1:0] rd, input logic [7:0] inp,
                           input logic [7:0] addr, input logic [7:0] wd);
    wr_en_regf_M    = wr_rf;
    wr_en_dmem_M    = wr_mem;
    rd_en_M         = rd_mem;
    out_port_sel_M  = out_sel;
    is_ret_M        = is_ret;
    mux_rdata_sel_M = sel;
    alu_out_M       = alu;
    rd_M            = rd;
    IN_PORT_M       = inp;
    mem_addr_M      = addr;
    mem_wd_M        = wd;
  endtask

  // One instruction through the stage. lat = BUSY cycle in which the memory
  // acks (1 = first BUSY cycle); lat = 0 means the memory never answers.
  task automatic applyStimulus(input logic wr_rf, input logic wr_mem, input logic rd_mem,
                               input logic out_sel, input logic is_ret, input logic [1:0] sel,
                               input logic [7:0] alu, input logic [1:0] rd, input logic [7:0] inp,
                               input logic [7:0] addr, input logic [7:0] wd,
                               input int lat, input logic spurious);
    logic       access;
    logic [7:0] rdata_ret, rq, exp_wb;
    logic       exp_ret;
    int         exp_stall, stall_cnt;

    @(negedge clk);
    setInputs(wr_rf, wr_mem, rd_mem, out_sel, is_ret, sel, alu, rd, inp, addr, wd);
    access    = wr_mem | rd_mem;
    rdata_ret = wr_mem ? 8'($urandom) : mem[addr];
    exp_stall = !access ? 0 : ((lat > 0) ? 1 + lat : 1 + MAX_WAIT);
    if (spurious) begin
      dmem_ack   = 1'b1;
      dmem_rdata = 8'hFF;
    end
    stall_cnt = 0;
    #1;
    while (stall_M === 1'b1 && stall_cnt < 40) begin
      if (stall_cnt >= 1) begin
        checkOutput("busy_req", 32'(dmem_req), 32'(1'b1));
        checkOutput("busy_we", 32'(dmem_we), 32'(wr_mem));
        checkOutput("busy_addr", 32'(dmem_addr), 32'(addr));
        checkOutput("busy_wdata", 32'(dmem_wdata), 32'(wd));
        checkOutput("bubble_wren", 32'(wr_en_regf_W), 32'(1'b0));
        checkOutput("bubble_ret", 32'(ret_valid_W), 32'(1'b0));
        if (stall_cnt == lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata_ret;
        end
      end
      stall_cnt++;
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 8'($urandom);
      @(negedge clk);
    end
    checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    checkOutput("commit_req", 32'(dmem_req), 32'(1'b0));

    @(posedge clk);
    #1;
    dmem_ack = 1'b0;

    // Reference outcome of the instruction at its retiring edge.
    if (access && lat == 0) err_m = 1'b1;
    rq = (access && lat > 0) ? rdata_ret : 8'h00;
    case (sel)
      2'b00:   exp_wb = alu;
      2'b01:   exp_wb = rq;
      2'b10:   exp_wb = inp;
      default: exp_wb = wd;
    endcase
    if (access && wr_mem && lat > 0) mem[addr] = wd;
    exp_ret = access && is_ret && rd_mem;
    if (exp_ret) ret_pc_m = rq;
    if (out_sel) out_m = alu;

    checkOutput("wb_wren", 32'(wr_en_regf_W), 32'(wr_rf));
    checkOutput("wb_rd", 32'(rd_W), 32'(rd));
    checkOutput("wb_data", 32'(wb_data_W), 32'(exp_wb));
    checkOutput("ret_valid", 32'(ret_valid_W), 32'(exp_ret));
    checkOutput("ret_pc", 32'(ret_pc_W), 32'(ret_pc_m));
    checkOutput("out_port", 32'(OUT_PORT), 32'(out_m));
    checkOutput("dmem_err", 32'(dmem_err), 32'(err_m));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"}, 32'(dmem_req), 32'(1'b0));
    checkOutput({tag, "_we"}, 32'(dmem_we), 32'(1'b0));
    checkOutput({tag, "_addr"}, 32'(dmem_addr), 32'(8'h00));
    checkOutput({tag, "_wdata"}, 32'(dmem_wdata), 32'(8'h00));
    checkOutput({tag, "_err"}, 32'(dmem_err), 32'(1'b0));
    checkOutput({tag, "_out"}, 32'(OUT_PORT), 32'(8'h00));
    checkOutput({tag, "_wren"}, 32'(wr_en_regf_W), 32'(1'b0));
    checkOutput({tag, "_rd"}, 32'(rd_W), 32'(2'b00));
    checkOutput({tag, "_wb"}, 32'(wb_data_W), 32'(8'h00));
    checkOutput({tag, "_retpc"}, 32'(ret_pc_W), 32'(8'h00));
    checkOutput({tag, "_retv"}, 32'(ret_valid_W), 32'(1'b0));
  endtask

  initial begin
    int         kind;
    logic       r_wr, r_rd, r_ret;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    out_m      = 8'h00;
    ret_pc_m   = 8'h00;
    err_m      = 1'b0;
    reset      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 8'h00;
    setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    checkOutput("reset_stall", 32'(stall_M), 32'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    // Directed: ALU op, load with immediate ack, slow store, RET.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h3C, 2'd2, 8'h11, 8'h00, 8'h00, 0, 1'b0);
    mem[8'h10] = 8'hA5;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h01, 2'd1, 8'h22, 8'h10, 8'h00, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 8'h02, 2'd3, 8'h33, 8'h20, 8'h77, 4, 1'b0);
    mem[8'h40] = 8'h42;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 8'h03, 2'd0, 8'h44, 8'h40, 8'h00, 2, 1'b0);

    // Random instruction mix with assorted ack latencies.
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 3);
      r_wr  = (kind == 3);
      r_rd  = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
      r_ret = (kind == 2) && ($urandom_range(0, 3) == 0);
      applyStimulus(1'($urandom), r_wr, r_rd, 1'($urandom), r_ret, 2'($urandom),
                    8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom_range(0, 15)),
                    8'($urandom), $urandom_range(1, 6), 1'b0);
    end

    // Timeout, then a stray ack in IDLE while an ALU op retires.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h05, 2'd1, 8'h00, 8'h50, 8'h00, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h6B, 2'd3, 8'h00, 8'h00, 8'h00, 0, 1'b1);
    checkOutput("spurious_req", 32'(dmem_req), 32'(1'b0));

    // Reset while BUSY, then a late ack that must be ignored.
    @(negedge clk);
    setInputs(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 8'h55, 2'd2, 8'h00, 8'h30, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("rstbusy_req", 32'(dmem_req), 32'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("rstbusy");
    @(negedge clk);
    reset = 1'b1;
    setInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00);
    dmem_ack   = 1'b1;
    dmem_rdata = 8'hEE;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    checkOutput("lateack_req", 32'(dmem_req), 32'(1'b0));
    checkOutput("lateack_stall", 32'(stall_M), 32'(1'b0));
    out_m    = 8'h00;
    ret_pc_m = 8'h00;
    err_m    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h99, 2'd0, 8'h00, 8'h00, 8'h00, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
